// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 1:8 TDM demultiplexer with frame lock, slot counter and error detect
module tdm_demux8 #(
    parameter logic [7:0] OUT_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       fsync,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    output logic       o4,
    output logic       o5,
    output logic       o6,
    output logic       o7,
    output logic       out_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t     state;
    logic [7:0] shadow;
    logic [7:0] obus;

    assign {o0, o1, o2, o3, o4, o5, o6, o7} = obus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            shadow    <= 8'h00;
            obus      <= OUT_RST;
            slot      <= 3'd0;
            locked    <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (din_valid) begin
                if (state == HUNT) begin
                    if (fsync) begin
                        shadow[0] <= din;
                        slot      <= 3'd1;
                        state     <= RUN;
                        locked    <= 1'b1;
                    end
                end else if (fsync) begin
                    // early sync abandons the partial frame and restarts at slot 0
                    if (slot != 3'd0)
                        frame_err <= 1'b1;
                    shadow[0] <= din;
                    slot      <= 3'd1;
                end else if (slot == 3'd0) begin
                    frame_err <= 1'b1;
                    state     <= HUNT;
                    locked    <= 1'b0;
                end else begin
                    shadow[slot] <= din;
                    slot         <= slot + 3'd1;
                    if (slot == 3'd7) begin
                        obus      <= {shadow[0], shadow[1], shadow[2], shadow[3],
                                      shadow[4], shadow[5], shadow[6], din};
                        out_valid <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - scoreboard bench for tdm_demux8
module tb_tdm_demux8;

    localparam logic [7:0] RST_VAL = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       fsync = 1'b0;
    logic       o0, o1, o2, o3, o4, o5, o6, o7;
    logic       out_valid;
    logic [2:0] slot;
    logic       locked;
    logic       frame_err;
    logic [7:0] frame_cnt;
    logic [7:0] obus;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int err_seen = 0;
    logic [7:0] exp_q[$];
    int ov_times[$];

    assign obus = {o0, o1, o2, o3, o4, o5, o6, o7};

    tdm_demux8 #(.OUT_RST(RST_VAL)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
        .out_valid(out_valid), .slot(slot), .locked(locked),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (frame_err)
            err_seen++;
        if (out_valid || frame_err)
            check("ov_err_excl", {31'd0, out_valid & frame_err}, 32'd0);
        if (out_valid) begin
            ov_times.push_back(cyc);
            if (exp_q.size() == 0)
                check("ov_unexpected", 32'd1, 32'd0);
            else
                check("frame_data", {24'd0, obus}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic send_bit(input logic b, input logic fs);
        din = b;
        fsync = fs;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic stall(input int n, input logic [2:0] exp_slot);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("slot_stall", {29'd0, slot}, {29'd0, exp_slot});
        end
    endtask

    // slot k carries f[7-k]; optional stalls are inserted before slots s1 and s2
    task automatic send_frame(input logic [7:0] f, input int s1, input int n1,
                              input int s2, input int n2);
        for (int k = 0; k < 8; k++) begin
            if (k == s1) stall(n1, 3'(k));
            if (k == s2) stall(n2, 3'(k));
            if (k == 7) exp_q.push_back(f);
            send_bit(f[7-k], k == 0);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] f;
        logic [7:0] cnt_before;

        #12;
        check("rst_o", {24'd0, obus}, {24'd0, RST_VAL});
        check("rst_slot", {29'd0, slot}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single frame
        send_frame(8'h80, -1, 0, -1, 0);
        check("t1_cnt", {24'd0, frame_cnt}, 32'd1);
        check("t1_locked", {31'd0, locked}, 32'd1);
        check("t1_slot", {29'd0, slot}, 32'd0);
        check("t1_q", exp_q.size(), 32'd0);

        // 2: back-to-back frames
        ov_times.delete();
        send_frame(8'h40, -1, 0, -1, 0);
        send_frame(8'h20, -1, 0, -1, 0);
        check("t2_nov", ov_times.size(), 32'd2);
        if (ov_times.size() == 2)
            check("t2_spacing", ov_times[1] - ov_times[0], 32'd8);
        check("t2_cnt", {24'd0, frame_cnt}, 32'd3);
        check("t2_err", err_seen, 32'd0);

        // 3: stalls between slots
        ov_times.delete();
        cnt_before = frame_cnt;
        send_frame(8'hB3, 3, 3, 7, 1);
        check("t3_o", {24'd0, obus}, 32'hB3);
        check("t3_cnt", {24'd0, frame_cnt}, {24'd0, cnt_before + 8'd1});

        // 4: early sync at slot 5, then a clean frame from that bit
        for (int k = 0; k < 5; k++)
            send_bit(1'b1, k == 0);
        check("t4_slot5", {29'd0, slot}, 32'd5);
        send_bit(1'b1, 1'b1);
        check("t4_err", err_seen, 32'd1);
        check("t4_hold", {24'd0, obus}, 32'hB3);
        check("t4_locked", {31'd0, locked}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            if (k == 7) exp_q.push_back(8'hFF);
            send_bit(1'b1, 1'b0);
        end
        send_frame(8'hA5, -1, 0, -1, 0);
        check("t4_o", {24'd0, obus}, 32'hA5);
        check("t4_locked2", {31'd0, locked}, 32'd1);

        // 5: missing sync drops lock
        cnt_before = frame_cnt;
        send_bit(1'b1, 1'b0);
        check("t5_err", err_seen, 32'd2);
        check("t5_locked", {31'd0, locked}, 32'd0);
        for (int k = 0; k < 8; k++)
            send_bit(k[0], 1'b0);
        check("t5_slot", {29'd0, slot}, 32'd0);
        check("t5_cnt", {24'd0, frame_cnt}, {24'd0, cnt_before});
        send_frame(8'hFF, -1, 0, -1, 0);
        check("t5_o", {24'd0, obus}, 32'hFF);
        check("t5_relock", {31'd0, locked}, 32'd1);

        // 6: asynchronous reset mid-frame
        for (int k = 0; k < 4; k++)
            send_bit(1'b0, k == 0);
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_o", {24'd0, obus}, {24'd0, RST_VAL});
        check("t6_cnt", {24'd0, frame_cnt}, 32'd0);
        check("t6_slot", {29'd0, slot}, 32'd0);
        check("t6_locked", {31'd0, locked}, 32'd0);
        check("t6_ov", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_q", exp_q.size(), 32'd0);
        for (int n = 0; n < 256; n++) begin
            f = 8'($urandom);
            send_frame(f, -1, 0, -1, 0);
            if (n == 254)
                check("t6_cnt255", {24'd0, frame_cnt}, 32'd255);
        end
        check("t6_wrap", {24'd0, frame_cnt}, 32'd0);
        check("t6_q_end", exp_q.size(), 32'd0);
        check("t6_err", err_seen, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
